// File: rtl/psram_pkg.sv
// Shared types and constants for the multi-port PSRAM controller.
package psram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_e;

  // Width of the wait/recover counter; covers WAIT_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  // Byte-lane strobes packed as {ub_n, lb_n}, active low.
  localparam logic [1:0] LANE_UPPER = 2'b01;
  localparam logic [1:0] LANE_LOWER = 2'b10;
  localparam logic [1:0] LANE_BOTH  = 2'b00;
  localparam logic [1:0] LANE_NONE  = 2'b11;

  // Idle level of the active-low strobes, and level of the async-mode tie-offs.
  localparam logic STROBE_IDLE = 1'b1;
  localparam logic TIE_LOW     = 1'b0;

  // Even byte address sits on the upper lane, odd on the lower lane.
  function automatic logic [1:0] lane_sel(input logic word, input logic a0);
    if (word) begin
      return LANE_BOTH;
    end
    return a0 ? LANE_LOWER : LANE_UPPER;
  endfunction

endpackage

// File: rtl/psram_rr_arbiter.sv
// Combinational request arbiter: fixed priority or round-robin from a pointer.
module psram_rr_arbiter #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              valid
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Walk the channels starting at the pointer (or 0) and take the first request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = (RR_MODE != 0) ? (32'(ptr) + i) : i;
      if (pos >= NUM_CH) begin
        pos = pos - NUM_CH;
      end
      pos_idx = IDX_W'(pos);
      if (!valid && req[pos_idx]) begin
        valid        = 1'b1;
        gnt[pos_idx] = 1'b1;
        gnt_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/psram_multiport_ctrl.sv
// Multi-channel asynchronous PSRAM controller: arbitrate, then one timed access at a time.
module psram_multiport_ctrl
  import psram_pkg::*;
#(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned WAIT_CYCLES    = 3,
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned RR_MODE        = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH-1:0]        word,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*16-1:0]     wdata,
  output logic [NUM_CH*16-1:0]     rdata,
  output logic [NUM_CH-1:0]        ack,
  output logic                     busy,
  output logic                     mem_oe_n,
  output logic                     mem_we_n,
  output logic                     ram_cs_n,
  output logic                     ram_ub_n,
  output logic                     ram_lb_n,
  output logic                     mem_adv_n,
  output logic                     mem_clk,
  output logic                     ram_cre,
  output logic [ADDR_W-2:0]        mem_adr,
  output logic [15:0]              mem_dout,
  output logic                     mem_dout_en,
  input  logic [15:0]              mem_din
);

  localparam int unsigned      IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_CH-1:0]       gnt_q, gnt_d;
  logic [NUM_CH-1:0]       ack_q, ack_d;
  logic                    acc_we_q, acc_we_d;
  logic                    acc_word_q, acc_word_d;
  logic                    acc_lo_q, acc_lo_d;
  logic                    cs_n_q, cs_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    ub_n_q, ub_n_d;
  logic                    lb_n_q, lb_n_d;
  logic [ADDR_W-2:0]       adr_q, adr_d;
  logic [15:0]             dout_q, dout_d;
  logic                    dout_en_q, dout_en_d;
  logic [NUM_CH-1:0][15:0] rdata_q, rdata_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic              sel_we;
  logic              sel_word;

  // A channel being acked this cycle must not be re-granted for the same request.
  assign eligible = req & ~ack_q;

  psram_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .RR_MODE(RR_MODE),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req    (eligible),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx),
    .valid  (arb_valid)
  );

  // Pick out the candidate channel's request fields.
  always_comb begin
    sel_addr  = addr[arb_idx*ADDR_W +: ADDR_W];
    sel_wdata = wdata[arb_idx*16 +: 16];
    sel_we    = we[arb_idx];
    sel_word  = word[arb_idx];
  end

  // Next-state and registered-pin logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    acc_we_d   = acc_we_q;
    acc_word_d = acc_word_q;
    acc_lo_d   = acc_lo_q;
    cs_n_d     = cs_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    ub_n_d     = ub_n_q;
    lb_n_d     = lb_n_q;
    adr_d      = adr_q;
    dout_d     = dout_q;
    dout_en_d  = dout_en_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d            = ACCESS;
          cnt_d              = '0;
          gnt_d              = arb_gnt;
          acc_we_d           = sel_we;
          acc_word_d         = sel_word;
          acc_lo_d           = sel_addr[0];
          cs_n_d             = 1'b0;
          oe_n_d             = sel_we;
          we_n_d             = ~sel_we;
          {ub_n_d, lb_n_d}   = lane_sel(sel_word, sel_addr[0]);
          adr_d              = sel_addr[ADDR_W-1:1];
          dout_d             = sel_word ? sel_wdata : {sel_wdata[7:0], sel_wdata[7:0]};
          dout_en_d          = sel_we;
          if (RR_MODE != 0) begin
            ptr_d = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WAIT_LAST) begin
          if (!acc_we_q) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (gnt_q[i]) begin
                rdata_d[i] = acc_word_q ? mem_din :
                             {8'h00, (acc_lo_q ? mem_din[7:0] : mem_din[15:8])};
              end
            end
          end
          ack_d            = gnt_q;
          cs_n_d           = STROBE_IDLE;
          oe_n_d           = STROBE_IDLE;
          we_n_d           = STROBE_IDLE;
          {ub_n_d, lb_n_d} = LANE_NONE;
          dout_en_d        = 1'b0;
          cnt_d            = '0;
          state_d          = (RECOVER_CYCLES == 0) ? IDLE : RECOVER;
        end
      end
      RECOVER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == REC_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pin registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      acc_we_q   <= 1'b0;
      acc_word_q <= 1'b0;
      acc_lo_q   <= 1'b0;
      cs_n_q     <= STROBE_IDLE;
      oe_n_q     <= STROBE_IDLE;
      we_n_q     <= STROBE_IDLE;
      ub_n_q     <= STROBE_IDLE;
      lb_n_q     <= STROBE_IDLE;
      adr_q      <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      acc_we_q   <= acc_we_d;
      acc_word_q <= acc_word_d;
      acc_lo_q   <= acc_lo_d;
      cs_n_q     <= cs_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      adr_q      <= adr_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign ack         = ack_q;
  assign busy        = (state_q != IDLE);
  assign ram_cs_n    = cs_n_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
  assign ram_ub_n    = ub_n_q;
  assign ram_lb_n    = lb_n_q;
  assign mem_adr     = adr_q;
  assign mem_dout    = dout_q;
  assign mem_dout_en = dout_en_q;
  assign mem_adv_n   = TIE_LOW;
  assign mem_clk     = TIE_LOW;
  assign ram_cre     = TIE_LOW;

endmodule

// File: tb/tb_psram_multiport_ctrl.sv
// Self-checking bench: fixed-priority instance with a read-data scoreboard,
// plus a round-robin instance for grant-order checks.
module tb_psram_multiport_ctrl;

  localparam int NCH = 3;
  localparam int AW  = 24;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0]    req, rr_req, we, word;
  logic [NCH*AW-1:0] addr;
  logic [NCH*16-1:0] wdata;
  logic [15:0]       mem_din;

  logic [NCH*16-1:0] rdata, rr_rdata;
  logic [NCH-1:0]    ack, rr_ack;
  logic busy, oe_n, we_n, cs_n, ub_n, lb_n, adv_n, mclk, cre, dout_en;
  logic rr_busy, rr_oe_n, rr_we_n, rr_cs_n, rr_ub_n, rr_lb_n, rr_adv_n, rr_mclk, rr_cre;
  logic rr_dout_en;
  logic [AW-2:0] adr, rr_adr;
  logic [15:0]   dout, rr_dout;
  logic [4:0]    strb, rr_strb;

  assign strb    = {cs_n, oe_n, we_n, ub_n, lb_n};
  assign rr_strb = {rr_cs_n, rr_oe_n, rr_we_n, rr_ub_n, rr_lb_n};

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] model_rd[NCH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  psram_multiport_ctrl #(
    .NUM_CH(NCH), .ADDR_W(AW), .WAIT_CYCLES(3), .RECOVER_CYCLES(1), .RR_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .mem_oe_n(oe_n), .mem_we_n(we_n), .ram_cs_n(cs_n), .ram_ub_n(ub_n), .ram_lb_n(lb_n),
    .mem_adv_n(adv_n), .mem_clk(mclk), .ram_cre(cre), .mem_adr(adr), .mem_dout(dout),
    .mem_dout_en(dout_en), .mem_din(mem_din)
  );

  psram_multiport_ctrl #(
    .NUM_CH(NCH), .ADDR_W(AW), .WAIT_CYCLES(3), .RECOVER_CYCLES(1), .RR_MODE(1)
  ) dut_rr (
    .clk(clk), .reset(reset), .req(rr_req), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .rdata(rr_rdata), .ack(rr_ack), .busy(rr_busy),
    .mem_oe_n(rr_oe_n), .mem_we_n(rr_we_n), .ram_cs_n(rr_cs_n), .ram_ub_n(rr_ub_n),
    .ram_lb_n(rr_lb_n), .mem_adv_n(rr_adv_n), .mem_clk(rr_mclk), .ram_cre(rr_cre),
    .mem_adr(rr_adr), .mem_dout(rr_dout), .mem_dout_en(rr_dout_en), .mem_din(mem_din)
  );

  // Expected rdata for a read, from the lane rules.
  function automatic logic [15:0] exp_read(input logic wd, input logic a0, input logic [15:0] d);
    if (wd) return d;
    return a0 ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
  endfunction

  task automatic set_ch(input int ch, input logic w, input logic wd, input logic [AW-1:0] a,
                        input logic [15:0] d);
    we[ch]              = w;
    word[ch]            = wd;
    addr[ch*AW +: AW]   = a;
    wdata[ch*16 +: 16]  = d;
  endtask

  // Queue the rdata expected at this channel's ack; writes leave it unchanged.
  task automatic push_exp(input int ch, input logic w, input logic wd, input logic a0,
                          input logic [15:0] din);
    if (!w) model_rd[ch] = exp_read(wd, a0, din);
    sb_q.push_back('{ch: ch, data: model_rd[ch]});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && ack === '0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: busy %b ack %b after 20 cycles, want idle", busy, ack);
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding access.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int c = 0; c < NCH; c++) begin
        if (ack[c] === 1'b1) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_ack: ch %0d acked with nothing outstanding", c);
          end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.ch != c || rdata[c*16 +: 16] !== mon_e.data) begin
              n_fail++;
              $display("FAIL sb_ack: got ch %0d rdata %h, want ch %0d rdata %h",
                       c, rdata[c*16 +: 16], mon_e.ch, mon_e.data);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (strb !== 5'b11111 || {adv_n, mclk, cre} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b/%b, want 11111/000", strb, {adv_n, mclk, cre});
    end
    n_checks++;
    if (adr !== '0 || dout !== '0 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got adr %h dout %h en %b, want 0", adr, dout, dout_en);
    end
    n_checks++;
    if (rdata !== '0 || ack !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata %h ack %b busy %b, want 0", rdata, ack, busy);
    end
    n_checks++;
    if (rr_strb !== 5'b11111 || rr_busy !== 1'b0 || rr_ack !== '0) begin
      n_fail++;
      $display("FAIL reset_rr: got strb %b busy %b ack %b", rr_strb, rr_busy, rr_ack);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || strb !== 5'b11111) begin
      n_fail++;
      $display("FAIL idle_no_req: got busy %b strb %b, want 0/11111", busy, strb);
    end
  endtask

  task automatic test_byte_read();
    set_ch(0, 1'b0, 1'b0, 24'h000004, 16'h0000);
    mem_din = 16'hA55A;
    push_exp(0, 1'b0, 1'b0, 1'b0, mem_din);
    req[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (strb !== 5'b00101 || adr !== 23'h000002 || dout_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_read_pins c%0d: got strb %b adr %h en %b busy %b, want 00101 2 0 1",
                 k, strb, adr, dout_en, busy);
      end
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b001) begin
      n_fail++;
      $display("FAIL byte_read_ack: got %b, want 001", ack);
    end
    req[0] = 1'b0;
    wait_idle();
  endtask

  task automatic test_byte_write();
    set_ch(1, 1'b1, 1'b0, 24'h000007, 16'h003C);
    push_exp(1, 1'b1, 1'b0, 1'b1, mem_din);
    req[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (strb !== 5'b01010 || dout !== 16'h3C3C || dout_en !== 1'b1 || adr !== 23'h000003) begin
        n_fail++;
        $display("FAIL byte_write_pins c%0d: got strb %b dout %h en %b adr %h, want 01010 3c3c 1 3",
                 k, strb, dout, dout_en, adr);
      end
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b010) begin
      n_fail++;
      $display("FAIL byte_write_ack: got %b, want 010", ack);
    end
    req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b000 || dout_en !== 1'b0 || cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_write_single_ack: got ack %b en %b cs_n %b, want 000 0 1",
               ack, dout_en, cs_n);
    end
    wait_idle();
  endtask

  task automatic test_word_read();
    set_ch(2, 1'b0, 1'b1, 24'h000011, 16'h0000);
    mem_din = 16'h1234;
    push_exp(2, 1'b0, 1'b1, 1'b1, mem_din);
    req[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (strb !== 5'b00100 || adr !== 23'h000008) begin
        n_fail++;
        $display("FAIL word_read_pins c%0d: got strb %b adr %h, want 00100 8", k, strb, adr);
      end
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b100) begin
      n_fail++;
      $display("FAIL word_read_ack: got %b, want 100", ack);
    end
    req[2] = 1'b0;
    wait_idle();
  endtask

  // Request fields change after grant; the access in flight must not follow them.
  task automatic test_capture();
    set_ch(0, 1'b0, 1'b0, 24'h000005, 16'h0000);
    mem_din = 16'hA55A;
    push_exp(0, 1'b0, 1'b0, 1'b1, mem_din);
    req[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (strb !== 5'b00110 || adr !== 23'h000002 || dout_en !== 1'b0) begin
        n_fail++;
        $display("FAIL capture_pins c%0d: got strb %b adr %h en %b, want 00110 2 0",
                 k, strb, adr, dout_en);
      end
      if (k == 1) set_ch(0, 1'b1, 1'b1, 24'h000100, 16'hFFFF);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b001) begin
      n_fail++;
      $display("FAIL capture_ack: got %b, want 001", ack);
    end
    req[0] = 1'b0;
    set_ch(0, 1'b0, 1'b0, 24'h000000, 16'h0000);
    wait_idle();
  endtask

  task automatic test_fixed_priority();
    int t0 = -1;
    int t2 = -1;
    set_ch(0, 1'b0, 1'b0, 24'h000020, 16'h0000);
    set_ch(2, 1'b0, 1'b1, 24'h000030, 16'h0000);
    mem_din = 16'hBEEF;
    push_exp(0, 1'b0, 1'b0, 1'b0, mem_din);
    push_exp(2, 1'b0, 1'b1, 1'b0, mem_din);
    req = 3'b101;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin
        t0 = cyc;
        req[0] = 1'b0;
      end
      if (ack[2] === 1'b1) begin
        t2 = cyc;
        req[2] = 1'b0;
        break;
      end
    end
    req = 3'b000;
    n_checks++;
    if (t0 != 4) begin
      n_fail++;
      $display("FAIL prio_ch0_latency: got %0d cycles, want 4", t0);
    end
    n_checks++;
    if (t2 != 9) begin
      n_fail++;
      $display("FAIL prio_ch2_latency: got %0d cycles, want 9", t2);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t[3] = '{-1, -1, -1};
    int n = 0;
    set_ch(1, 1'b1, 1'b1, 24'h000040, 16'h1357);
    for (int k = 0; k < 3; k++) push_exp(1, 1'b1, 1'b1, 1'b0, mem_din);
    req[1] = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) begin
        t[n] = cyc;
        n++;
        if (n == 3) begin
          req[1] = 1'b0;
          break;
        end
      end
    end
    req[1] = 1'b0;
    n_checks++;
    if (t[0] != 4 || t[1] - t[0] != 5 || t[2] - t[1] != 5) begin
      n_fail++;
      $display("FAIL back_to_back_spacing: got acks at %0d %0d %0d, want 4 9 14", t[0], t[1], t[2]);
    end
    wait_idle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order[5] = '{-1, -1, -1, -1, -1};
    int exp_order[5];
    int ptr = 0;
    int n = 0;
    for (int k = 0; k < 5; k++) begin
      exp_order[k] = ptr;
      ptr = (ptr + 1) % NCH;
    end
    set_ch(0, 1'b0, 1'b0, 24'h0, 16'h0);
    set_ch(1, 1'b0, 1'b0, 24'h0, 16'h0);
    set_ch(2, 1'b0, 1'b0, 24'h0, 16'h0);
    rr_req = 3'b111;
    for (int cyc = 1; cyc <= 60 && n < 5; cyc++) begin
      @(negedge clk);
      if (rr_ack !== 3'b000) begin
        n_checks++;
        if (!$onehot(rr_ack)) begin
          n_fail++;
          $display("FAIL rr_onehot: got %b, want one-hot", rr_ack);
        end
        for (int c = 0; c < NCH; c++) if (rr_ack[c] === 1'b1) order[n] = c;
        n++;
      end
    end
    rr_req = 3'b000;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (order[k] != exp_order[k] || (k > 0 && order[k] == order[k-1])) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got ch %0d, want ch %0d", k, order[k], exp_order[k]);
      end
    end
    for (int i = 0; i < 20 && rr_busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    set_ch(0, 1'b0, 1'b1, 24'h000040, 16'h0000);
    mem_din = 16'h7777;
    push_exp(0, 1'b0, 1'b1, 1'b0, mem_din);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_active: got cs_n %b busy %b, want 0 1", cs_n, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (strb !== 5'b11111 || ack !== '0 || busy !== 1'b0 || rdata !== '0 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got strb %b ack %b busy %b rdata %h en %b",
               strb, ack, busy, rdata, dout_en);
    end
    model_rd[1] = 16'h0000;
    model_rd[2] = 16'h0000;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (cs_n !== 1'b0 || ack !== '0) begin
        n_fail++;
        $display("FAIL rst_reserve_pins c%0d: got cs_n %b ack %b, want 0 000", k, cs_n, ack);
      end
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_reserve_ack: got %b, want 001", ack);
    end
    req[0] = 1'b0;
    wait_idle();
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    rr_req   = '0;
    we       = '0;
    word     = '0;
    addr     = '0;
    wdata    = '0;
    mem_din  = '0;
    for (int c = 0; c < NCH; c++) model_rd[c] = 16'h0000;

    test_reset();
    test_byte_read();
    test_byte_write();
    test_word_read();
    test_capture();
    test_fixed_priority();
    test_back_to_back();
    test_round_robin();
    test_reset_mid_access();

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d outstanding accesses, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
